// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the core-to-shared-memory path.
// Holds FSM and op encodings used by the responder and its arbiter.
package gpu_mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OP_LD,
        OP_ST
    } op_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting core at or after ptr.
// Purely combinational; grant is one-hot, idx is its position.
import gpu_mem_pkg::*;

module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    int j;

    // Scan from ptr upward, wrapping, and stop at the first request.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/shared_mem_responder.sv
// Serves load/store requests from several cores on one byte array.
// One access at a time: IDLE grants, ACCESS touches the array, RESP ends.
import gpu_mem_pkg::*;

module shared_mem_responder #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int DEPTH     = 2 ** ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          mem_req_ld,
    input  logic [NUM_CORES-1:0]          mem_req_st,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr_shared_memory,
    input  logic [NUM_CORES*DATA_W-1:0]   mem_dat_st,
    output logic [NUM_CORES*DATA_W-1:0]   mem_dat,
    output logic [NUM_CORES-1:0]          val_data
);

    localparam int IDX_W = idx_w(NUM_CORES);

    state_t                 state;
    op_t                    op_q;
    logic [IDX_W-1:0]       core_q;
    logic [IDX_W-1:0]       rr_ptr;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdat_q;
    logic [NUM_CORES-1:0]   served;

    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   grant;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdat;
    op_t                    sel_op;

    logic [DATA_W-1:0]      mem_array [DEPTH];
    logic [ADDR_W-1:0]      ram_addr;
    logic                   ram_we;
    logic [DATA_W-1:0]      rd_q;

    // A core already answered stays out until it drops both requests.
    assign eligible = (mem_req_ld | mem_req_st) & ~served;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Load wins when a core raises both requests.
    always_comb begin
        sel_addr = addr_shared_memory[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wdat = mem_dat_st[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_op   = (|(mem_req_ld & grant)) ? OP_LD : OP_ST;
    end

    // The winner's address is read while granting; the latched one is written.
    always_comb begin
        ram_addr = (state == IDLE) ? sel_addr : addr_q;
        ram_we   = reset && (state == ACCESS) && (op_q == OP_ST);
    end

    // Single-port synchronous array, contents deliberately unreset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_array[ram_addr] <= wdat_q;
        end
        rd_q <= mem_array[ram_addr];
    end

    // Grant, access, respond; outputs and bookkeeping registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= OP_LD;
            core_q   <= '0;
            rr_ptr   <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            served   <= '0;
            val_data <= '0;
            mem_dat  <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!mem_req_ld[k] && !mem_req_st[k]) begin
                    served[k] <= 1'b0;
                end
            end
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        core_q <= gnt_idx;
                        addr_q <= sel_addr;
                        wdat_q <= sel_wdat;
                        op_q   <= sel_op;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    val_data[core_q] <= 1'b1;
                    if (op_q == OP_LD) begin
                        mem_dat[int'(core_q)*DATA_W +: DATA_W] <= rd_q;
                    end
                    state <= RESP;
                end
                RESP: begin
                    val_data       <= '0;
                    served[core_q] <= 1'b1;
                    rr_ptr <= (core_q == IDX_W'(NUM_CORES - 1)) ?
                              '0 : core_q + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder with 4 cores.
// Expected values are hand-derived from the handshake timing.
module tb_shared_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ld;
    logic [3:0]  st;
    logic [47:0] addr;
    logic [31:0] wdat;
    logic [31:0] mem_dat;
    logic [3:0]  val;

    int checks = 0;
    int errors = 0;

    shared_mem_responder #(
        .NUM_CORES (4),
        .ADDR_W    (12),
        .DATA_W    (8),
        .DEPTH     (4096)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_ld         (ld),
        .mem_req_st         (st),
        .addr_shared_memory (addr),
        .mem_dat_st         (wdat),
        .mem_dat            (mem_dat),
        .val_data           (val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic l, input logic s,
                            input logic [11:0] a, input logic [7:0] d);
        ld[k] = l;
        st[k] = s;
        addr[k*12 +: 12] = a;
        wdat[k*8 +: 8] = d;
    endtask

    // One full request: raise, expect pulse two edges later, drop.
    task automatic do_op(input string tag, input int k, input logic l,
                         input logic s, input logic [11:0] a,
                         input logic [7:0] d, input logic chk_d,
                         input logic [7:0] expd);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        set_core(k, l, s, a, d);
        tick();
        chk({tag, "_pre"}, {28'h0, val}, 32'h0);
        tick();
        chk({tag, "_val"}, {28'h0, val}, {28'h0, onehot});
        if (chk_d) chk({tag, "_dat"}, {24'h0, mem_dat[k*8 +: 8]}, {24'h0, expd});
        tick();
        chk({tag, "_post"}, {28'h0, val}, 32'h0);
        ld[k] = 1'b0;
        st[k] = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        ld    = '0;
        st    = '0;
        addr  = '0;
        wdat  = '0;
        tick();
        tick();
        chk("rst_val", {28'h0, val}, 32'h0);
        chk("rst_dat", mem_dat, 32'h0);
        reset = 1'b1;
        tick();

        // Store then load on core 0.
        do_op("st_a5", 0, 1'b0, 1'b1, 12'h005, 8'hA5, 1'b1, 8'h00);
        do_op("ld_a5", 0, 1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 8'hA5);

        // Preload 0x10..0x13, then reset so rr_ptr restarts at 0.
        for (int k = 0; k < 4; k++) begin
            do_op("pre", 0, 1'b0, 1'b1, 12'(k), 8'(8'h10 + k), 1'b0, 8'h00);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // All four cores load at once.
        for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 12'(k), 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("all_gap", {28'h0, val}, 32'h0);
            tick();
            chk("all_order", {28'h0, val}, {28'h0, 4'b0001 << k});
            chk("all_dat", {24'h0, mem_dat[k*8 +: 8]}, 32'h10 + k);
            tick();
            chk("all_post", {28'h0, val}, 32'h0);
            ld[k] = 1'b0;
        end
        chk("all_hold", mem_dat, 32'h13121110);
        tick();

        // Core 2 holds its request one cycle past the pulse.
        set_core(2, 1'b1, 1'b0, 12'h002, 8'h00);
        tick();
        chk("hold_pre", {28'h0, val}, 32'h0);
        tick();
        chk("hold_val", {28'h0, val}, 32'h4);
        chk("hold_dat", {24'h0, mem_dat[23:16]}, 32'h12);
        tick();
        chk("hold_p1", {28'h0, val}, 32'h0);
        tick();
        chk("hold_p2", {28'h0, val}, 32'h0);
        ld[2] = 1'b0;
        tick();
        chk("no_reserve", {28'h0, val}, 32'h0);
        do_op("reraise", 2, 1'b1, 1'b0, 12'h002, 8'h00, 1'b1, 8'h12);

        // Core 1 served, re-raises with core 3; pointer favours core 3.
        set_core(1, 1'b1, 1'b0, 12'h001, 8'h00);
        tick();
        chk("rr_pre", {28'h0, val}, 32'h0);
        tick();
        chk("rr_c1", {28'h0, val}, 32'h2);
        chk("rr_c1_dat", {24'h0, mem_dat[15:8]}, 32'h11);
        tick();
        ld[1] = 1'b0;
        tick();
        ld[1] = 1'b1;
        set_core(3, 1'b1, 1'b0, 12'h003, 8'h00);
        tick();
        chk("rr_gap", {28'h0, val}, 32'h0);
        tick();
        chk("rr_c3_first", {28'h0, val}, 32'h8);
        chk("rr_c3_dat", {24'h0, mem_dat[31:24]}, 32'h13);
        tick();
        ld[3] = 1'b0;
        tick();
        chk("rr_gap2", {28'h0, val}, 32'h0);
        tick();
        chk("rr_c1_second", {28'h0, val}, 32'h2);
        tick();
        ld[1] = 1'b0;
        tick();

        // Store aborted by reset during ACCESS must not land.
        do_op("st_3c", 0, 1'b0, 1'b1, 12'hFFF, 8'h3C, 1'b0, 8'h00);
        set_core(0, 1'b0, 1'b1, 12'hFFF, 8'h5A);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_val", {28'h0, val}, 32'h0);
        chk("abort_dat", mem_dat, 32'h0);
        st[0] = 1'b0;
        tick();
        chk("abort_val2", {28'h0, val}, 32'h0);
        reset = 1'b1;
        tick();
        do_op("ld_fff", 0, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 8'h3C);

        // Both requests raised: treated as a load, location unchanged.
        do_op("st_77", 0, 1'b0, 1'b1, 12'h020, 8'h77, 1'b0, 8'h00);
        do_op("both", 0, 1'b1, 1'b1, 12'h020, 8'h99, 1'b1, 8'h77);
        do_op("ld_020", 1, 1'b1, 1'b0, 12'h020, 8'h00, 1'b1, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
